// File: rtl/channel_sequencer.sv
// Frame commutator: fetches one ADC sample per channel and emits it as a shaped valid pulse.
// Optional build macro SEQ_SKIP_IGNORED_EN drops IGNORED_CHANNEL from every frame.
module channel_sequencer #(
  parameter logic [4:0] NUM_CHANNELS    = 5'd18,
  parameter logic [3:0] VALID_HIGH      = 4'd4,
  parameter logic [3:0] VALID_LOW       = 4'd2,
  parameter logic [7:0] ADC_TIMEOUT     = 8'd200,
  parameter logic [4:0] IGNORED_CHANNEL = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] adcData,
  input  logic        adcAck,
  output logic        adcReq,
  output logic [4:0]  adcCh,
  output logic [11:0] data,
  output logic        valid,
  output logic [4:0]  address,
  output logic        busy,
  output logic        frameDone,
  output logic        adcErr
);

`ifdef SEQ_SKIP_IGNORED_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam logic [5:0] FIRST_CH =
    (SKIP_EN && (IGNORED_CHANNEL == 5'd0)) ? 6'd1 : 6'd0;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    PRESENT,
    GAP,
    DONE
  } stateType;

  stateType    state;
  logic [7:0]  timer;
  logic [8:0]  timerNext;
  logic [5:0]  nextCh;
  logic        lastCh;

  function automatic logic [5:0] nextChannel(input logic [5:0] c);
    logic [5:0] n;
    n = c + 6'd1;
    if (SKIP_EN && (n == {1'b0, IGNORED_CHANNEL}))
      n = n + 6'd1;
    return n;
  endfunction

  // adcCh doubles as the frame's channel counter
  assign nextCh    = nextChannel({1'b0, adcCh});
  assign lastCh    = (nextCh >= {1'b0, NUM_CHANNELS});
  assign timerNext = {1'b0, timer} + 9'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= 8'd0;
      adcReq    <= 1'b0;
      adcCh     <= 5'd0;
      data      <= 12'd0;
      valid     <= 1'b0;
      address   <= 5'd0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      adcErr    <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            adcErr <= 1'b0;
            timer  <= 8'd0;
            if (FIRST_CH >= {1'b0, NUM_CHANNELS}) begin
              frameDone <= 1'b1;
              state     <= DONE;
            end else begin
              busy   <= 1'b1;
              adcCh  <= FIRST_CH[4:0];
              adcReq <= 1'b1;
              state  <= REQUEST;
            end
          end
        end

        REQUEST: begin
          // An ack on the final allowed cycle still beats the timeout
          if (adcAck) begin
            data    <= adcData;
            address <= adcCh;
            valid   <= 1'b1;
            adcReq  <= 1'b0;
            timer   <= 8'd0;
            state   <= PRESENT;
          end else if (timerNext >= {1'b0, ADC_TIMEOUT}) begin
            data    <= 12'hFFF;
            address <= adcCh;
            valid   <= 1'b1;
            adcReq  <= 1'b0;
            adcErr  <= 1'b1;
            timer   <= 8'd0;
            state   <= PRESENT;
          end else begin
            timer <= timerNext[7:0];
          end
        end

        PRESENT: begin
          if (timerNext >= {5'd0, VALID_HIGH}) begin
            valid <= 1'b0;
            timer <= 8'd0;
            state <= GAP;
          end else begin
            timer <= timerNext[7:0];
          end
        end

        GAP: begin
          if (timerNext >= {5'd0, VALID_LOW}) begin
            timer <= 8'd0;
            if (lastCh) begin
              busy      <= 1'b0;
              frameDone <= 1'b1;
              state     <= DONE;
            end else begin
              adcCh  <= nextCh[4:0];
              adcReq <= 1'b1;
              state  <= REQUEST;
            end
          end else begin
            timer <= timerNext[7:0];
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_sequencer.sv
// Testbench for channel_sequencer: per-cycle frame-timeline model plus directed scenarios.
// Honours SEQ_SKIP_IGNORED_EN when the bench is built with it.
module tb_channel_sequencer;

  localparam int NUM = 18;
  localparam int VH  = 4;
  localparam int VL  = 2;
  localparam int TMO = 200;
  localparam int IGN = 1;
`ifdef SEQ_SKIP_IGNORED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int WORDS = SKIP ? NUM - 1 : NUM;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] adcData;
  logic        adcAck;
  logic        adcReq;
  logic [4:0]  adcCh;
  logic [11:0] data;
  logic        valid;
  logic [4:0]  address;
  logic        busy;
  logic        frameDone;
  logic        adcErr;

  channel_sequencer #(
    .NUM_CHANNELS(5'd18),
    .VALID_HIGH(4'd4),
    .VALID_LOW(4'd2),
    .ADC_TIMEOUT(8'd200),
    .IGNORED_CHANNEL(5'd1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .adcData(adcData),
    .adcAck(adcAck),
    .adcReq(adcReq),
    .adcCh(adcCh),
    .data(data),
    .valid(valid),
    .address(address),
    .busy(busy),
    .frameDone(frameDone),
    .adcErr(adcErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          ackDelay [32];
  logic [11:0] adcValue [32];

  logic [31:0] expQ [$];
  logic [4:0]  lastCh;
  logic [4:0]  lastAddr;
  logic [11:0] lastData;
  logic        lastErr;

  int wordAddr [$];
  int wordData [$];
  int highRuns [$];
  int doneCount;
  int cycle;
  int lastDoneCycle;
  int doneToReq;
  bit pendingDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic req, input logic [4:0] ch, input logic v,
                                       input logic [11:0] d, input logic [4:0] a,
                                       input logic b, input logic fd, input logic e);
    return {5'd0, req, ch, v, d, a, b, fd, e};
  endfunction

  function automatic int wordIndex(input int ch);
    return (SKIP && ch > IGN) ? ch - 1 : ch;
  endfunction

  // Whole-frame timeline: each word is REQUEST (ack delay or timeout) + VH high + VL low
  task automatic genFrame();
    logic        err;
    logic [11:0] d;
    logic [4:0]  a;
    logic [4:0]  lc;
    logic [4:0]  c5;
    int          rl;
    bit          tmo;
    err = 1'b0;
    d   = lastData;
    a   = lastAddr;
    lc  = lastCh;
    for (int c = 0; c < NUM; c++) begin
      if (SKIP && c == IGN) continue;
      c5 = c[4:0];
      if (ackDelay[c] == 0 || ackDelay[c] > TMO) begin
        rl = TMO; tmo = 1'b1;
      end else begin
        rl = ackDelay[c]; tmo = 1'b0;
      end
      repeat (rl) expQ.push_back(pack(1'b1, c5, 1'b0, d, a, 1'b1, 1'b0, err));
      d   = tmo ? 12'hFFF : adcValue[c];
      a   = c5;
      err = err | tmo;
      repeat (VH) expQ.push_back(pack(1'b0, c5, 1'b1, d, a, 1'b1, 1'b0, err));
      repeat (VL) expQ.push_back(pack(1'b0, c5, 1'b0, d, a, 1'b1, 1'b0, err));
      lc = c5;
    end
    expQ.push_back(pack(1'b0, lc, 1'b0, d, a, 1'b0, 1'b1, err));
    lastCh   = lc;
    lastData = d;
    lastAddr = a;
    lastErr  = err;
  endtask

  // ADC front end: ack on the ackDelay-th REQUEST cycle (0 = never)
  initial begin
    int reqCnt;
    reqCnt  = 0;
    adcAck  = 1'b0;
    adcData = 12'hABC;
    forever begin
      @(negedge clk);
      if (adcReq === 1'b1) begin
        reqCnt++;
        if (ackDelay[adcCh] != 0 && reqCnt == ackDelay[adcCh]) begin
          adcAck  = 1'b1;
          adcData = adcValue[adcCh];
        end else begin
          adcAck  = 1'b0;
          adcData = 12'hABC;
        end
      end else begin
        reqCnt  = 0;
        adcAck  = 1'b0;
        adcData = 12'hABC;
      end
    end
  end

  // Compare process: every cycle against the model, plus word/pulse bookkeeping
  initial begin
    logic [31:0] act;
    logic [31:0] exp;
    logic        prevValid;
    logic        prevReq;
    int          run;
    prevValid = 1'b0;
    prevReq   = 1'b0;
    run       = 0;
    cycle     = 0;
    lastCh    = 5'd0;
    lastAddr  = 5'd0;
    lastData  = 12'd0;
    lastErr   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cycle++;
      act = pack(adcReq, adcCh, valid, data, address, busy, frameDone, adcErr);
      if (reset !== 1'b1) begin
        expQ.delete();
        lastCh = 5'd0; lastAddr = 5'd0; lastData = 12'd0; lastErr = 1'b0;
        checkOutput("reset-cycle", act, 32'd0);
        prevValid = 1'b0; prevReq = 1'b0; pendingDone = 1'b0; run = 0;
      end else begin
        if (expQ.size() > 0) begin
          exp = expQ.pop_front();
          checkOutput("frame-cycle", act, exp);
        end else begin
          exp = pack(1'b0, lastCh, 1'b0, lastData, lastAddr, 1'b0, 1'b0, lastErr);
          checkOutput("idle-cycle", act, exp);
          if (start === 1'b1) genFrame();
        end
        if (valid && !prevValid) begin
          wordAddr.push_back(int'(address));
          wordData.push_back(int'(data));
          run = 0;
        end
        if (valid) run++;
        if (!valid && prevValid) highRuns.push_back(run);
        if (frameDone) begin
          doneCount++;
          lastDoneCycle = cycle;
          pendingDone   = 1'b1;
        end
        if (adcReq && !prevReq && pendingDone) begin
          doneToReq   = cycle - lastDoneCycle;
          pendingDone = 1'b0;
        end
        prevValid = valid;
        prevReq   = adcReq;
      end
    end
  end

  task automatic applyStimulus(input logic s);
    @(negedge clk);
    start = s;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearWords();
    wordAddr.delete();
    wordData.delete();
    highRuns.delete();
    doneCount = 0;
  endtask

  task automatic waitFrameDone(input int budget, input string name);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    while (k < budget && !seen) begin
      @(negedge clk);
      #2;
      if (frameDone === 1'b1) seen = 1'b1;
      k++;
    end
    checkOutput({name, "-frameDone-seen"}, 32'(seen), 32'd1);
  endtask

  task automatic runFrame(input string name);
    clearWords();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    waitFrameDone(800, name);
    waitCycles(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    int expAddr;
    int savedWords;
    bit seen;
    for (int i = 0; i < 32; i++) begin
      ackDelay[i] = 2;
      adcValue[i] = 12'(i * 16);
    end
    doneCount   = 0;
    doneToReq   = -1;
    pendingDone = 1'b0;
    reset = 1'b0;
    start = 1'b0;

    // Reset state
    waitCycles(3);
    #2;
    checkOutput("reset-valid", 32'(valid), 32'd0);
    checkOutput("reset-busy", 32'(busy), 32'd0);
    checkOutput("reset-adcReq", 32'(adcReq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    waitCycles(3);

    // Nominal frame, with start->adcReq latency pinned
    clearWords();
    applyStimulus(1'b1);
    #2;
    checkOutput("latency-req-before", 32'(adcReq), 32'd0);
    applyStimulus(1'b0);
    #2;
    checkOutput("latency-req-after", 32'(adcReq), 32'd1);
    checkOutput("latency-busy", 32'(busy), 32'd1);
    waitFrameDone(800, "nominal");
    waitCycles(2);
    checkOutput("nominal-words", 32'(wordAddr.size()), 32'(WORDS));
    checkOutput("nominal-word0-data", 32'(wordData[0]), 32'h000);
    checkOutput("nominal-word1-addr", 32'(wordAddr[1]), SKIP ? 32'd2 : 32'd1);
    checkOutput("nominal-word1-data", 32'(wordData[1]), SKIP ? 32'h020 : 32'h010);
    checkOutput("nominal-last-addr", 32'(wordAddr[WORDS-1]), 32'd17);
    checkOutput("nominal-last-data", 32'(wordData[WORDS-1]), 32'h110);
    bad = 0;
    for (int i = 0; i < wordAddr.size(); i++) begin
      expAddr = (SKIP && i >= IGN) ? i + 1 : i;
      if (wordAddr[i] != expAddr || wordData[i] != expAddr * 16) bad++;
    end
    checkOutput("nominal-sequence-bad", 32'(bad), 32'd0);
    bad = 0;
    foreach (highRuns[i]) if (highRuns[i] != 4) bad++;
    checkOutput("nominal-high-width-bad", 32'(bad), 32'd0);
    checkOutput("nominal-high-count", 32'(highRuns.size()), 32'(WORDS));
    checkOutput("nominal-done-count", 32'(doneCount), 32'd1);
    checkOutput("nominal-adcErr", 32'(adcErr), 32'd0);

    // Channel 5 never acks: fill value and sticky error
    ackDelay[5] = 0;
    runFrame("timeout");
    checkOutput("timeout-words", 32'(wordAddr.size()), 32'(WORDS));
    checkOutput("timeout-ch5-addr", 32'(wordAddr[wordIndex(5)]), 32'd5);
    checkOutput("timeout-ch5-data", 32'(wordData[wordIndex(5)]), 32'hFFF);
    checkOutput("timeout-ch6-data", 32'(wordData[wordIndex(6)]), 32'h060);
    checkOutput("timeout-adcErr-sticky", 32'(adcErr), 32'd1);
    ackDelay[5] = 2;
    clearWords();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    waitCycles(2);
    #2;
    checkOutput("timeout-adcErr-cleared", 32'(adcErr), 32'd0);
    waitFrameDone(800, "after-timeout");
    waitCycles(2);
    checkOutput("after-timeout-adcErr", 32'(adcErr), 32'd0);

    // Ack on the 200th REQUEST cycle of channel 3 beats the timeout
    ackDelay[3] = 200;
    adcValue[3] = 12'h5A5;
    runFrame("edge-ack");
    checkOutput("edge-ack-ch3-addr", 32'(wordAddr[wordIndex(3)]), 32'd3);
    checkOutput("edge-ack-ch3-data", 32'(wordData[wordIndex(3)]), 32'h5A5);
    checkOutput("edge-ack-adcErr", 32'(adcErr), 32'd0);
    ackDelay[3] = 2;
    adcValue[3] = 12'h030;

    // start toggling while busy must not add frames
    clearWords();
    applyStimulus(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 800 && !seen; k++) begin
      @(negedge clk);
      start = (k % 3 == 0);
      #2;
      if (frameDone === 1'b1) begin
        seen  = 1'b1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("toggle-frameDone-seen", 32'(seen), 32'd1);
    waitCycles(30);
    checkOutput("toggle-words", 32'(wordAddr.size()), 32'(WORDS));
    checkOutput("toggle-done-count", 32'(doneCount), 32'd1);

    // start held high: back-to-back frames, one idle cycle after frameDone
    clearWords();
    @(negedge clk);
    start = 1'b1;
    waitFrameDone(800, "held-first");
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (adcReq === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("held-second-req-seen", 32'(seen), 32'd1);
    checkOutput("held-done-to-req", 32'(doneToReq), 32'd2);
    waitFrameDone(800, "held-second");
    waitCycles(3);
    checkOutput("held-done-count", 32'(doneCount), 32'd2);
    checkOutput("held-words", 32'(wordAddr.size()), 32'(2 * WORDS));

    // Reset while channel 9 is being presented
    clearWords();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (valid === 1'b1 && address === 5'd9) seen = 1'b1;
    end
    checkOutput("reset-mid-reached-ch9", 32'(seen), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset-mid-valid", 32'(valid), 32'd0);
    checkOutput("reset-mid-busy", 32'(busy), 32'd0);
    checkOutput("reset-mid-adcReq", 32'(adcReq), 32'd0);
    checkOutput("reset-mid-data", 32'(data), 32'd0);
    checkOutput("reset-mid-address", 32'(address), 32'd0);
    savedWords = wordAddr.size();
    waitCycles(2);
    reset = 1'b1;
    waitCycles(12);
    checkOutput("reset-mid-no-words", 32'(wordAddr.size()), 32'(savedWords));
    checkOutput("reset-mid-no-done", 32'(doneCount), 32'd0);
    runFrame("post-reset");
    checkOutput("post-reset-first-addr", 32'(wordAddr[0]), 32'd0);
    checkOutput("post-reset-words", 32'(wordAddr.size()), 32'(WORDS));

    waitCycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
